sync_fifo_resp: RTL and testbench

- Synchronous single-clock FIFO: the responder end of the write/read-enable FIFO interface our FIFO BFM drives.
- Stores bytes pushed with wr_enb/wr_data and returns them in order on rd_enb/rd_data.
- Reports full, empty, almost-full, almost-empty, overrun and underrun status back to the initiator.
- Used as the FIFO DUT in the verification bench and as a reusable buffer in datapaths.

---
 rtl/sync_fifo_resp.sv | 75 +++++++
 tb/tb_sync_fifo_resp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_resp.sv
// Single-clock byte FIFO answering a write/read-enable initiator.
// Occupancy is held in a counter; every status flag is a plain decode of it.
module sync_fifo_resp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 7,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic                  fifo_overrun,
  output logic                  fifo_underrun,
  output logic [ADDR_WIDTH:0]   fifo_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign fifo_count        = count;
  assign fifo_full         = (count == DEPTH_CNT);
  assign fifo_empty        = (count == '0);
  assign fifo_almost_full  = (count >= AF_CNT) && !fifo_full;
  assign fifo_almost_empty = (count <= AE_CNT) && !fifo_empty;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign wr_ok = wr_enb && (!fifo_full || rd_enb);
  assign rd_ok = rd_enb && !fifo_empty;

  // Storage is never cleared; reset only blocks the write on that edge.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_data       <= '0;
      fifo_overrun  <= 1'b0;
      fifo_underrun <= 1'b0;
    end else begin
      fifo_overrun  <= wr_enb && fifo_full && !rd_enb;
      fifo_underrun <= rd_enb && fifo_empty;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_resp.sv
// Bench for sync_fifo_resp: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed expectations.
module tb_sync_fifo_resp;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_enb = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_enb = 1'b0;
  logic [7:0] rd_data;
  logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic       fifo_overrun, fifo_underrun;
  logic [3:0] fifo_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];
  logic [7:0] m_rd  = 8'h00;
  logic       m_ovr = 1'b0;
  logic       m_und = 1'b0;

  sync_fifo_resp #(
    .DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .AF_LEVEL(7), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_data(wr_data), .rd_enb(rd_enb),
    .rd_data(rd_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
    .fifo_overrun(fifo_overrun), .fifo_underrun(fifo_underrun),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored bytes, updated from the sampled inputs.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rd  = 8'h00;
      m_ovr = 1'b0;
      m_und = 1'b0;
    end else begin
      m_ovr = wr_enb && (q.size() == DEPTH) && !rd_enb;
      m_und = rd_enb && (q.size() == 0);
      if (rd_enb && q.size() != 0) m_rd = q.pop_front();
      if (wr_enb && !m_ovr) q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count",  fifo_count,        q.size());
      chk("m_full",   fifo_full,         q.size() == DEPTH);
      chk("m_empty",  fifo_empty,        q.size() == 0);
      chk("m_afull",  fifo_almost_full,  q.size() >= 7 && q.size() < DEPTH);
      chk("m_aempty", fifo_almost_empty, q.size() > 0 && q.size() <= 1);
      chk("m_rdata",  rd_data,           m_rd);
      chk("m_ovr",    fifo_overrun,      m_ovr);
      chk("m_und",    fifo_underrun,     m_und);
    end
  end

  // One clock edge with the given inputs; returns #1 after that edge, inputs idle.
  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd);
    @(negedge clk);
    rst = r; wr_enb = w; wr_data = d; rd_enb = rd;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_af", fifo_almost_full, 0);
    chk("rst_ae", fifo_almost_empty, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_rdata", rd_data, 8'h00);
    chk("rst_ovr", fifo_overrun, 0);
    chk("rst_und", fifo_underrun, 0);

    // Fill, overrun, drain
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    chk("fill_full", fifo_full, 1);
    chk("fill_af", fifo_almost_full, 0);
    chk("fill_count", fifo_count, 8);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    chk("ovr_pulse", fifo_overrun, 1);
    chk("ovr_count", fifo_count, 8);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovr_drop", fifo_overrun, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain_data", rd_data, 32'(i));
    end
    chk("drain_empty", fifo_empty, 1);

    // Underrun, including a back-to-back pair
    do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("und_pulse", fifo_underrun, 1);
    chk("und_empty", fifo_empty, 1);
    chk("und_rdata", rd_data, 8'h00);
    chk("und_count", fifo_count, 0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("und_hold", fifo_underrun, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("und_drop", fifo_underrun, 0);

    // Almost full
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    chk("af_below", fifo_almost_full, 0);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("af_count", fifo_count, 7);
    chk("af_set", fifo_almost_full, 1);
    chk("af_full", fifo_full, 0);
    chk("af_ovr", fifo_overrun, 0);

    // Almost empty
    do_reset();
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    chk("ae_at2", fifo_almost_empty, 0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ae_rdata", rd_data, 8'h00);
    chk("ae_count", fifo_count, 1);
    chk("ae_set", fifo_almost_empty, 1);
    chk("ae_empty", fifo_empty, 0);
    chk("ae_und", fifo_underrun, 0);

    // Simultaneous read/write, then full + simultaneous across the wrap
    do_reset();
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("sim_rdata", rd_data, 8'h11);
    chk("sim_count", fifo_count, 3);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("sim_r1", rd_data, 8'h22);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("sim_r2", rd_data, 8'h33);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("sim_r3", rd_data, 8'h55);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    chk("wrap_full", fifo_full, 1);
    step(1'b0, 1'b1, 8'hC0, 1'b1);
    chk("wrap_rd0", rd_data, 8'h80);
    chk("wrap_ovr", fifo_overrun, 0);
    chk("wrap_count", fifo_count, 8);
    step(1'b0, 1'b1, 8'hC1, 1'b1);
    chk("wrap_rd1", rd_data, 8'h81);
    for (int i = 2; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("wrap_order", rd_data, 32'(8'h80 + i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("wrap_c0", rd_data, 8'hC0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("wrap_c1", rd_data, 8'hC1);

    // Simultaneous on empty: write kept, read rejected
    step(1'b0, 1'b1, 8'h99, 1'b1);
    chk("se_und", fifo_underrun, 1);
    chk("se_count", fifo_count, 1);
    chk("se_rdata", rd_data, 8'hC1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("se_read", rd_data, 8'h99);

    // Reset overrides a simultaneous write
    step(1'b0, 1'b1, 8'h12, 1'b0);
    step(1'b1, 1'b1, 8'h34, 1'b1);
    chk("rstov_count", fifo_count, 0);
    chk("rstov_rdata", rd_data, 8'h00);
    chk("rstov_empty", fifo_empty, 1);

    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
